// File: rtl/dram_block_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dram_block_adapter
// Purpose  : L2 whole-block read/write requests <-> subblock-strobed memory
//            port. Optional write ack: define DRAM_ADAPTER_WRITE_ACK_EN.
// Revision : 1.0
// ============================================================================
module dram_block_adapter #(
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 512,
  parameter int SUBBLOCKS  = 4,
  parameter int SUB_LOG2   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [ADDR_BITS-1:0]            req_addr,
  input  logic [BLOCK_BITS-1:0]           req_wdata,
  output logic                            resp_valid,
  output logic [BLOCK_BITS-1:0]           resp_rdata,
  output logic [ADDR_BITS-1:0]            mem_addr,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [SUB_LOG2-1:0]             mem_dinDstrobe,
  output logic [BLOCK_BITS/SUBBLOCKS-1:0] mem_din,
  input  logic [SUB_LOG2-1:0]             mem_doutDstrobe,
  input  logic [BLOCK_BITS/SUBBLOCKS-1:0] mem_dout,
  input  logic                            mem_dready,
  input  logic                            mem_accR,
  input  logic                            mem_accW,
  output logic                            err
);

  localparam int                   c_BEAT_BITS  = BLOCK_BITS / SUBBLOCKS;
  localparam logic [ADDR_BITS-1:0] c_ALIGN_MASK = ~ADDR_BITS'(BLOCK_BITS / 8 - 1);
  localparam logic [SUB_LOG2-1:0]  c_LAST_BEAT  = SUB_LOG2'(SUBBLOCKS - 1);

  localparam logic [2:0] c_ST_IDLE       = 3'd0;
  localparam logic [2:0] c_ST_RD_ISSUE   = 3'd1;
  localparam logic [2:0] c_ST_RD_COLLECT = 3'd2;
  localparam logic [2:0] c_ST_WR_WAIT    = 3'd3;
  localparam logic [2:0] c_ST_WR_SEND    = 3'd4;
  localparam logic [2:0] c_ST_RESP       = 3'd5;
  localparam logic [2:0] c_ST_WR_ACK     = 3'd6;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [BLOCK_BITS-1:0] r_wdata;
  logic [SUBBLOCKS-1:0]  r_rcvd;
  logic [SUBBLOCKS-1:0]  w_slot_set;
  logic [SUB_LOG2-1:0]   r_beat;
  logic [SUB_LOG2-1:0]   w_beat_inc;
  logic                  w_accept;
  logic                  w_rd_start;
  logic                  w_wr_start;
  logic                  w_req_ready_nxt;
  logic                  w_resp_valid_nxt;
  logic                  w_mem_en_nxt;
  logic                  w_mem_we_nxt;

  assign w_accept   = req_valid & req_ready;
  assign w_rd_start = (r_state == c_ST_RD_ISSUE) & mem_accR;
  assign w_wr_start = (r_state == c_ST_WR_WAIT) & mem_accW;
  assign w_beat_inc = r_beat + SUB_LOG2'(1);

  // Slot mask contributed by the current read beat; completion counts unique slots.
  always_comb begin
    w_slot_set = '0;
    if (mem_dready) begin
      w_slot_set[mem_doutDstrobe] = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = req_we ? c_ST_WR_WAIT : c_ST_RD_ISSUE;
        end
      end
      c_ST_RD_ISSUE: begin
        if (mem_accR) w_state_nxt = c_ST_RD_COLLECT;
      end
      c_ST_RD_COLLECT: begin
        if (&(r_rcvd | w_slot_set)) w_state_nxt = c_ST_RESP;
      end
      c_ST_WR_WAIT: begin
        if (mem_accW) w_state_nxt = c_ST_WR_SEND;
      end
      c_ST_WR_SEND: begin
        if (r_beat == c_LAST_BEAT) begin
`ifdef DRAM_ADAPTER_WRITE_ACK_EN
          w_state_nxt = c_ST_WR_ACK;
`else
          w_state_nxt = c_ST_IDLE;
`endif
        end
      end
      c_ST_WR_ACK: begin
        // accW returning high means the memory has drained the write.
        if (mem_accW) w_state_nxt = c_ST_RESP;
      end
      c_ST_RESP: begin
        w_state_nxt = c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // Next values of the registered control outputs
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == c_ST_IDLE);
    w_resp_valid_nxt = (w_state_nxt == c_ST_RESP);
    w_mem_en_nxt     = w_rd_start;
    w_mem_we_nxt     = (w_state_nxt == c_ST_WR_SEND);
  end

  // State register and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= c_ST_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      err            <= 1'b0;
      mem_addr       <= '0;
      mem_dinDstrobe <= '0;
      mem_din        <= '0;
      resp_rdata     <= '0;
      r_wdata        <= '0;
      r_rcvd         <= '0;
      r_beat         <= '0;
    end else begin
      r_state    <= w_state_nxt;
      req_ready  <= w_req_ready_nxt;
      resp_valid <= w_resp_valid_nxt;
      mem_en     <= w_mem_en_nxt;
      mem_we     <= w_mem_we_nxt;

      if (w_accept) begin
        mem_addr <= req_addr & c_ALIGN_MASK;
        r_wdata  <= req_wdata;
      end

      // Beats are stored even when flagged as errors.
      if (mem_dready) begin
        resp_rdata[int'(mem_doutDstrobe) * c_BEAT_BITS +: c_BEAT_BITS] <= mem_dout;
        if ((r_state != c_ST_RD_COLLECT) || r_rcvd[mem_doutDstrobe]) begin
          err <= 1'b1;
        end
      end

      if (w_rd_start) begin
        r_rcvd <= '0;
        r_beat <= '0;
      end else if (r_state == c_ST_RD_COLLECT) begin
        r_rcvd <= r_rcvd | w_slot_set;
      end

      if (w_wr_start) begin
        r_beat         <= '0;
        mem_dinDstrobe <= '0;
        mem_din        <= r_wdata[c_BEAT_BITS-1:0];
      end else if ((r_state == c_ST_WR_SEND) && (w_state_nxt == c_ST_WR_SEND)) begin
        r_beat         <= w_beat_inc;
        mem_dinDstrobe <= w_beat_inc;
        mem_din        <= r_wdata[int'(w_beat_inc) * c_BEAT_BITS +: c_BEAT_BITS];
      end

      if ((r_state == c_ST_WR_ACK) && (w_state_nxt == c_ST_RESP)) begin
        resp_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_block_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dram_block_adapter
// Purpose  : Randomised directed bench with a block-level memory model.
// Revision : 1.0
// ============================================================================
module tb_dram_block_adapter;

  localparam int AB = 32;
  localparam int BB = 512;
  localparam int SB = 4;
  localparam int SL = 2;
  localparam int BW = BB / SB;

  typedef int unsigned ord_t [4];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AB-1:0] req_addr = '0;
  logic [BB-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [BB-1:0] resp_rdata;
  logic [AB-1:0] mem_addr;
  logic          mem_en;
  logic          mem_we;
  logic [SL-1:0] mem_dinDstrobe;
  logic [BW-1:0] mem_din;
  logic [SL-1:0] mem_doutDstrobe = '0;
  logic [BW-1:0] mem_dout = '0;
  logic          mem_dready = 1'b0;
  logic          mem_accR = 1'b1;
  logic          mem_accW = 1'b1;
  logic          err;

  always #5 clk = ~clk;

  dram_block_adapter #(
    .ADDR_BITS(AB), .BLOCK_BITS(BB), .SUBBLOCKS(SB), .SUB_LOG2(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_dinDstrobe(mem_dinDstrobe), .mem_din(mem_din),
    .mem_doutDstrobe(mem_doutDstrobe), .mem_dout(mem_dout),
    .mem_dready(mem_dready), .mem_accR(mem_accR), .mem_accW(mem_accW),
    .err(err)
  );

  int checks = 0;
  int failures = 0;

  logic [BB-1:0] mem [logic [31:0]];
  int unsigned   beat_ord[$];
  logic [BW-1:0] beat_dat[$];

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:6], 6'd0};
  endfunction

  function automatic logic [BB-1:0] rand_blk();
    logic [BB-1:0] b;
    for (int i = 0; i < BB / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic plan(input logic [BB-1:0] blk, input ord_t ord);
    beat_ord.delete();
    beat_dat.delete();
    for (int k = 0; k < SB; k++) begin
      beat_ord.push_back(ord[k]);
      beat_dat.push_back(blk[ord[k]*BW +: BW]);
    end
  endtask

  task automatic plan_shuffle(input logic [BB-1:0] blk);
    ord_t o;
    int unsigned j, tmp;
    o = '{0, 1, 2, 3};
    for (int i = SB - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = o[i]; o[i] = o[j]; o[j] = tmp;
    end
    plan(blk, o);
  endtask

  // Memory side of a block read: stall, command, latency, then the planned beats.
  task automatic do_read(input logic [31:0] addr, input int pre_stall, input int lat, input string tag);
    logic [BB-1:0] exp;
    int en_cnt, waited;
    bit addr_bad, stall_bad, early;
    exp = '0;
    foreach (beat_ord[k]) exp[beat_ord[k]*BW +: BW] = beat_dat[k];
    chk_i({tag, "_ready_idle"}, int'(req_ready), 1);
    mem_accR = (pre_stall == 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom;
    stall_bad = 0;
    for (int i = 0; i < pre_stall; i++) begin
      if (mem_en || req_ready) stall_bad = 1;
      @(negedge clk);
    end
    if (pre_stall > 0) chk_i({tag, "_stall_quiet"}, int'(stall_bad), 0);
    mem_accR = 1'b1;
    @(negedge clk);
    chk_i({tag, "_en_pulse"}, int'(mem_en), 1);
    chk_i({tag, "_addr"}, int'(mem_addr), int'(align(addr)));
    en_cnt = 1; addr_bad = 0; early = 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      en_cnt += int'(mem_en);
      if (mem_addr !== align(addr)) addr_bad = 1;
    end
    foreach (beat_ord[k]) begin
      mem_dready = 1'b1; mem_doutDstrobe = SL'(beat_ord[k]); mem_dout = beat_dat[k];
      @(negedge clk);
      en_cnt += int'(mem_en);
      if (mem_addr !== align(addr)) addr_bad = 1;
      if (resp_valid && (k != beat_ord.size() - 1)) early = 1;
    end
    mem_dready = 1'b0;
    waited = 0;
    while (!resp_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk_i({tag, "_resp_latency"}, waited, 0);
    chk_i({tag, "_no_early_resp"}, int'(early), 0);
    chk_w({tag, "_rdata"}, resp_rdata, exp);
    chk_i({tag, "_en_count"}, en_cnt, 1);
    chk_i({tag, "_addr_held"}, int'(addr_bad), 0);
    @(negedge clk);
    chk_i({tag, "_resp_one_cycle"}, int'(resp_valid), 0);
    chk_i({tag, "_ready_back"}, int'(req_ready), 1);
  endtask

  // Memory side of a block write: accW drops after the first beat for `lat` cycles.
  task automatic do_write(input logic [31:0] addr, input logic [BB-1:0] data, input int pre_stall,
                          input int lat, input string tag);
    int nb, first_cyc, last_cyc, resp_cnt, resp_cyc, restore_cyc, ready_cyc, busy;
    bit stall_bad, strobe_bad, addr_bad;
    logic [BB-1:0] resp_dat;
    nb = 0; first_cyc = -1; last_cyc = -1; resp_cnt = 0; resp_cyc = -1;
    restore_cyc = -1; ready_cyc = -1; busy = 0;
    stall_bad = 0; strobe_bad = 0; addr_bad = 0; resp_dat = '1;
    chk_i({tag, "_ready_idle"}, int'(req_ready), 1);
    mem_accW = (pre_stall == 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_wdata = rand_blk();
    for (int i = 0; i < pre_stall; i++) begin
      if (mem_we || req_ready) stall_bad = 1;
      @(negedge clk);
    end
    if (pre_stall > 0) chk_i({tag, "_stall_quiet"}, int'(stall_bad), 0);
    mem_accW = 1'b1;
    for (int cyc = 0; cyc < lat + 12; cyc++) begin
      @(negedge clk);
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          mem_accW = 1'b1;
          restore_cyc = cyc;
        end
      end
      if (mem_we) begin
        if (nb < SB) begin
          if (int'(mem_dinDstrobe) != nb) strobe_bad = 1;
          chk_w({tag, "_din"}, BB'(mem_din), BB'(data[nb*BW +: BW]));
        end
        if (mem_addr !== align(addr)) addr_bad = 1;
        if (nb == 0) begin
          first_cyc = cyc;
          mem_accW = 1'b0;
          busy = lat;
        end
        last_cyc = cyc;
        nb++;
      end
      if (resp_valid) begin
        resp_cnt++;
        resp_cyc = cyc;
        resp_dat = resp_rdata;
      end
      if (req_ready && ready_cyc < 0) ready_cyc = cyc;
    end
    chk_i({tag, "_beats"}, nb, SB);
    chk_i({tag, "_consecutive"}, last_cyc - first_cyc, SB - 1);
    chk_i({tag, "_strobes"}, int'(strobe_bad), 0);
    chk_i({tag, "_addr_held"}, int'(addr_bad), 0);
`ifdef DRAM_ADAPTER_WRITE_ACK_EN
    chk_i({tag, "_ack_count"}, resp_cnt, 1);
    chk_i({tag, "_ack_after_accw"}, resp_cyc, restore_cyc + 1);
    chk_w({tag, "_ack_data"}, resp_dat, '0);
    chk_i({tag, "_ready_cycle"}, ready_cyc, resp_cyc + 1);
`else
    chk_i({tag, "_no_resp"}, resp_cnt, 0);
    chk_i({tag, "_ready_cycle"}, ready_cyc, last_cyc + 1);
`endif
    mem_accW = 1'b1;
    mem[align(addr)] = data;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BB-1:0] blk, wd;
    logic [31:0] a;
    bit found;

    repeat (3) @(negedge clk);
    chk_i("rst_req_ready", int'(req_ready), 1);
    chk_i("rst_resp_valid", int'(resp_valid), 0);
    chk_i("rst_mem_en", int'(mem_en), 0);
    chk_i("rst_mem_we", int'(mem_we), 0);
    chk_i("rst_err", int'(err), 0);
    chk_i("rst_mem_addr", int'(mem_addr), 0);
    chk_i("rst_dinDstrobe", int'(mem_dinDstrobe), 0);
    chk_w("rst_mem_din", BB'(mem_din), '0);
    chk_w("rst_resp_rdata", resp_rdata, '0);
    reset = 1'b1;
    @(negedge clk);

    // Byte-ramp row, in-order beats, latency 5
    for (int i = 0; i < BB / 8; i++) blk[i*8 +: 8] = 8'(i);
    mem[32'h0001_0040] = blk;
    plan(blk, '{0, 1, 2, 3});
    do_read(32'h0001_0040, 0, 5, "rd_ramp");
    chk_i("rd_ramp_err", int'(err), 0);

    // Patterned write then shuffled readback
    for (int i = 0; i < SB; i++) wd[i*BW +: BW] = {8{8'hA5, 8'(i + 1)}};
    do_write(32'h0001_0080, wd, 0, 10, "wr_pat");
    plan_shuffle(mem[32'h0001_0080]);
    do_read(32'h0001_0080, 0, 3, "rb_pat");

    // Read held off by accR low for 20 cycles
    a = $urandom; blk = rand_blk();
    plan(blk, '{0, 1, 2, 3});
    do_read(a, 20, 3, "rd_stall");

    // Out-of-order beats
    a = $urandom; blk = rand_blk();
    plan(blk, '{2, 0, 3, 1});
    do_read(a, 0, 2, "rd_ooo");
    chk_i("rd_ooo_err", int'(err), 0);

    // Random write/readback pairs
    for (int n = 0; n < 4; n++) begin
      a = $urandom; blk = rand_blk();
      do_write(a, blk, int'($urandom_range(0, 3)), int'($urandom_range(4, 12)), "wr_rnd");
      plan_shuffle(mem[align(a)]);
      do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), "rb_rnd");
    end
    chk_i("err_clean", int'(err), 0);

    // Duplicate strobe 1 carrying new data: err set, later data kept
    a = $urandom; blk = rand_blk();
    plan(blk, '{2, 1, 0, 3});
    beat_ord.insert(2, 1);
    beat_dat.insert(2, blk[BW-1:0] ^ {4{$urandom}});
    do_read(a, 0, 2, "rd_dup");
    chk_i("err_dup", int'(err), 1);
    plan_shuffle(rand_blk());
    do_read($urandom, 0, 2, "rd_after_dup");
    chk_i("err_sticky", int'(err), 1);

    // Asynchronous reset while beat 1 of a write is on the bus
    a = $urandom; blk = rand_blk();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = blk;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_we && mem_dinDstrobe == SL'(1)) found = 1;
    end
    chk_i("rst_mid_reach_beat1", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    chk_i("rst_mid_mem_we", int'(mem_we), 0);
    chk_i("rst_mid_req_ready", int'(req_ready), 1);
    chk_i("rst_mid_err", int'(err), 0);
    chk_i("rst_mid_mem_addr", int'(mem_addr), 0);
    chk_i("rst_mid_dinDstrobe", int'(mem_dinDstrobe), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    a = $urandom; blk = rand_blk();
    plan_shuffle(blk);
    do_read(a, 1, 4, "rd_after_rst");
    chk_i("rd_after_rst_err", int'(err), 0);

    // Stray beat while idle
    mem_dready = 1'b1; mem_doutDstrobe = '0; mem_dout = blk[BW-1:0];
    @(negedge clk);
    mem_dready = 1'b0;
    @(negedge clk);
    chk_i("err_stray", int'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
